frv_counters: RTL and testbench

Memory-mapped timer and performance-counter block sitting directly beside `frv_core`. It produces the `ctr_time`, `ctr_cycle` and `ctr_instret` values and the `int_mtime` timer interrupt that the core consumes. It takes the core's `instr_ret`, `ctr_inhibit_cy` and `ctr_inhibit_ir` outputs back in. Software reaches `mtime` and `mtimecmp` through a req/gnt slave port that uses the same signalling as the core's dmem bus.

---
 rtl/frv_counters_pkg.sv | 46 ++++
 rtl/frv_counter64.sv | 32 +++
 rtl/frv_counters.sv | 146 ++++++++++++++
 tb/tb_frv_counters.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_counters_pkg.sv
// Shared definitions for the timer / performance-counter block.
package frv_counters_pkg;

  // Register offsets inside the 16-byte window
  localparam logic [3:0] FRV_CTR_MTIME_LO    = 4'h0;
  localparam logic [3:0] FRV_CTR_MTIME_HI    = 4'h4;
  localparam logic [3:0] FRV_CTR_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] FRV_CTR_MTIMECMP_HI = 4'hC;

  // Slots in the counter array
  localparam int NUM_CTR      = 4;
  localparam int CTR_MTIME    = 0;
  localparam int CTR_MTIMECMP = 1;
  localparam int CTR_CYCLE    = 2;
  localparam int CTR_INSTRET  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } mmio_st_e;

  typedef struct packed {
    logic        req;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
  } mmio_req_t;

  typedef struct packed {
    logic        error;
    logic [31:0] rdata;
  } mmio_rsp_t;

  // Byte-lane merge of new write data over an old 32-bit word
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/frv_counter64.sv
// 64-bit counter with a byte-strobed 32-bit half write that beats the increment.
module frv_counter64
  import frv_counters_pkg::*;
#(
  parameter logic [63:0] RST_VAL = 64'h0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        i_inc,
  input  logic        i_wen,
  input  logic        i_hi,
  input  logic [3:0]  i_strb,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_val
);

  logic [63:0] r_val;

  // Write replaces one half (other half holds, no increment); otherwise count
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn)
      r_val <= RST_VAL;
    else if (i_wen) begin
      if (i_hi) r_val[63:32] <= strb_merge(r_val[63:32], i_wdata, i_strb);
      else      r_val[31:0]  <= strb_merge(r_val[31:0],  i_wdata, i_strb);
    end else if (i_inc)
      r_val <= r_val + 64'd1;
  end

  assign o_val = r_val;

endmodule

// File: rtl/frv_counters.sv
// mtime/mtimecmp timer, cycle and instret counters, and the MMIO slave port.
module frv_counters
  import frv_counters_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
  parameter int unsigned TIME_DIV  = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        instr_ret,
  input  logic        inhibit_cy,
  input  logic        inhibit_ir,
  output logic [63:0] ctr_time,
  output logic [63:0] ctr_cycle,
  output logic [63:0] ctr_instret,
  output logic        int_mtime,
  input  logic        mmio_req,
  input  logic        mmio_wen,
  input  logic [3:0]  mmio_strb,
  input  logic [31:0] mmio_wdata,
  input  logic [31:0] mmio_addr,
  output logic        mmio_gnt,
  output logic        mmio_error,
  output logic [31:0] mmio_rdata
);

  localparam int PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TIME_DIV - 1);

  mmio_st_e                     r_st, w_st_nxt;
  mmio_req_t                    w_req;
  mmio_rsp_t                    r_rsp, w_rsp;
  logic                         w_accept;
  logic [31:0]                  w_off;
  logic                         w_err;
  logic                         w_wr;
  logic [PW-1:0]                r_pre;
  logic                         w_tick;
  logic                         r_int;
  logic [NUM_CTR-1:0]           w_inc;
  logic [NUM_CTR-1:0]           w_wen;
  logic [NUM_CTR-1:0][63:0]     w_val;

  assign w_req = '{req: mmio_req, wen: mmio_wen, strb: mmio_strb,
                   wdata: mmio_wdata, addr: mmio_addr};

  // Wrapping subtraction: addresses below the base land far above 15
  assign w_off = w_req.addr - MMIO_BASE;
  assign w_err = (w_off > 32'd15) || (w_req.addr[1:0] != 2'b00);

  // An all-zero strobe is a legal no-op, so it must not suppress the tick
  assign w_wr  = w_accept && w_req.wen && !w_err && (|w_req.strb);

  assign w_tick = (r_pre == PRE_LAST);

  always_comb begin
    w_inc               = '0;
    w_inc[CTR_MTIME]    = w_tick;
    w_inc[CTR_CYCLE]    = !inhibit_cy;
    w_inc[CTR_INSTRET]  = instr_ret && !inhibit_ir;
    w_wen               = '0;
    w_wen[CTR_MTIME]    = w_wr && !w_off[3];
    w_wen[CTR_MTIMECMP] = w_wr &&  w_off[3];
  end

  for (genvar g = 0; g < NUM_CTR; g++) begin : g_ctr
    frv_counter64 #(
      .RST_VAL((g == CTR_MTIMECMP) ? {64{1'b1}} : 64'h0)
    ) u_ctr (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .i_inc    (w_inc[g]),
      .i_wen    (w_wen[g]),
      .i_hi     (w_off[2]),
      .i_strb   (w_req.strb),
      .i_wdata  (w_req.wdata),
      .o_val    (w_val[g])
    );
  end

  // mtime prescaler: wraps to zero on the tick cycle
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) r_pre <= '0;
    else           r_pre <= w_tick ? '0 : r_pre + PW'(1);
  end

  // Interrupt is a registered unsigned compare of the current register values
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) r_int <= 1'b0;
    else           r_int <= (w_val[CTR_MTIME] >= w_val[CTR_MTIMECMP]);
  end

  // Read mux sampled at acceptance, before that edge's increments land
  always_comb begin
    w_rsp = '{error: 1'b0, rdata: 32'h0};
    if (w_err)
      w_rsp.error = 1'b1;
    else begin
      case (w_off[3:0])
        FRV_CTR_MTIME_LO:    w_rsp.rdata = w_val[CTR_MTIME][31:0];
        FRV_CTR_MTIME_HI:    w_rsp.rdata = w_val[CTR_MTIME][63:32];
        FRV_CTR_MTIMECMP_LO: w_rsp.rdata = w_val[CTR_MTIMECMP][31:0];
        FRV_CTR_MTIMECMP_HI: w_rsp.rdata = w_val[CTR_MTIMECMP][63:32];
        default:             w_rsp.rdata = 32'h0;
      endcase
    end
  end

  // Slave FSM state register
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) r_st <= ST_IDLE;
    else           r_st <= w_st_nxt;
  end

  // Slave FSM next state; a req still high in RESP is the finishing transfer
  always_comb begin
    w_st_nxt = r_st;
    w_accept = 1'b0;
    mmio_gnt = 1'b0;
    case (r_st)
      ST_IDLE: if (w_req.req) begin
        w_accept = 1'b1;
        w_st_nxt = ST_RESP;
      end
      ST_RESP: begin
        mmio_gnt = 1'b1;
        w_st_nxt = ST_IDLE;
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  // Response latch, loaded on acceptance
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn)     r_rsp <= '0;
    else if (w_accept) r_rsp <= w_rsp;
  end

  assign mmio_error  = r_rsp.error;
  assign mmio_rdata  = r_rsp.rdata;
  assign int_mtime   = r_int;
  assign ctr_time    = w_val[CTR_MTIME];
  assign ctr_cycle   = w_val[CTR_CYCLE];
  assign ctr_instret = w_val[CTR_INSTRET];

endmodule

// File: tb/tb_frv_counters.sv
// Directed + randomized bench for frv_counters against a cycle-level reference model.
module tb_frv_counters;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          TD   = 4;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        instr_ret = 1'b0, inhibit_cy = 1'b0, inhibit_ir = 1'b0;
  logic [63:0] ctr_time, ctr_cycle, ctr_instret;
  logic        int_mtime;
  logic        mmio_req = 1'b0, mmio_wen = 1'b0;
  logic [3:0]  mmio_strb = 4'h0;
  logic [31:0] mmio_wdata = 32'h0, mmio_addr = 32'h0;
  logic        mmio_gnt, mmio_error;
  logic [31:0] mmio_rdata;

  int n_tot  = 0;
  int n_pass = 0;

  // reference model state
  logic [63:0] m_time, m_cmp, m_cyc, m_ir;
  int          m_pre;
  logic        m_int, m_busy, m_err;
  logic [31:0] m_rd;
  bit          rnd_on = 1'b0;

  frv_counters #(.MMIO_BASE(BASE), .TIME_DIV(TD)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .instr_ret(instr_ret), .inhibit_cy(inhibit_cy), .inhibit_ir(inhibit_ir),
    .ctr_time(ctr_time), .ctr_cycle(ctr_cycle), .ctr_instret(ctr_instret),
    .int_mtime(int_mtime),
    .mmio_req(mmio_req), .mmio_wen(mmio_wen), .mmio_strb(mmio_strb),
    .mmio_wdata(mmio_wdata), .mmio_addr(mmio_addr),
    .mmio_gnt(mmio_gnt), .mmio_error(mmio_error), .mmio_rdata(mmio_rdata)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] w,
                                         input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? w[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] off);
    case (off[3:2])
      2'd0:    return m_time[31:0];
      2'd1:    return m_time[63:32];
      2'd2:    return m_cmp[31:0];
      default: return m_cmp[63:32];
    endcase
  endfunction

  function automatic void model_reset();
    m_time = 64'h0; m_cmp = {64{1'b1}}; m_cyc = 64'h0; m_ir = 64'h0;
    m_pre = 0; m_int = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_rd = 32'h0;
  endfunction

  // One clock: advance the model from the inputs seen at the edge, then compare
  task automatic step();
    logic acc, err, tick;
    logic [31:0] off;
    logic [63:0] t_n, c_n;
    @(posedge g_clk);
    acc  = mmio_req && !m_busy;
    off  = mmio_addr - BASE;
    err  = (off >= 32'd16) || (mmio_addr[1:0] != 2'b00);
    tick = (m_pre == TD - 1);
    t_n  = tick ? m_time + 64'd1 : m_time;
    c_n  = m_cmp;
    if (acc) begin
      m_err = err;
      m_rd  = err ? 32'h0 : rd_model(off);
      if (mmio_wen && !err && mmio_strb != 4'h0) begin
        case (off[3:2])
          2'd0:    t_n = {m_time[63:32], bmerge(m_time[31:0], mmio_wdata, mmio_strb)};
          2'd1:    t_n = {bmerge(m_time[63:32], mmio_wdata, mmio_strb), m_time[31:0]};
          2'd2:    c_n = {m_cmp[63:32], bmerge(m_cmp[31:0], mmio_wdata, mmio_strb)};
          default: c_n = {bmerge(m_cmp[63:32], mmio_wdata, mmio_strb), m_cmp[31:0]};
        endcase
      end
    end
    m_int  = (m_time >= m_cmp);
    m_pre  = tick ? 0 : m_pre + 1;
    if (!inhibit_cy) m_cyc = m_cyc + 64'd1;
    if (instr_ret && !inhibit_ir) m_ir = m_ir + 64'd1;
    m_busy = acc;
    m_time = t_n;
    m_cmp  = c_n;
    #1;
    chk("cycle", ctr_cycle, m_cyc);
    chk("instret", ctr_instret, m_ir);
    chk("time", ctr_time, m_time);
    chk("int", 64'(int_mtime), 64'(m_int));
    chk("gnt", 64'(mmio_gnt), 64'(m_busy));
    if (m_busy) begin
      chk("rdata", 64'(mmio_rdata), 64'(m_rd));
      chk("error", 64'(mmio_error), 64'(m_err));
    end
    if (rnd_on) begin
      instr_ret  = 1'($urandom_range(0, 1));
      inhibit_cy = ($urandom_range(0, 3) == 0);
      inhibit_ir = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic wen, input logic [3:0] strb,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    mmio_req = 1'b1; mmio_addr = addr; mmio_wen = wen; mmio_strb = strb; mmio_wdata = wd;
    step();
    rd = mmio_rdata; er = mmio_error;
    mmio_req = 1'b0; mmio_wen = 1'b0;
    step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_time"}, ctr_time, 64'h0);
    chk({tag, "_cycle"}, ctr_cycle, 64'h0);
    chk({tag, "_instret"}, ctr_instret, 64'h0);
    chk({tag, "_int"}, 64'(int_mtime), 64'h0);
    chk({tag, "_gnt"}, 64'(mmio_gnt), 64'h0);
    chk({tag, "_rdata"}, 64'(mmio_rdata), 64'h0);
    chk({tag, "_error"}, 64'(mmio_error), 64'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cnt;
    logic [31:0] addrs [6];

    // power-on reset
    model_reset();
    repeat (2) @(posedge g_clk);
    #1;
    chk_reset("por");
    g_resetn = 1'b1;
    repeat (3) step();

    // reset asserted while a write is in RESP
    mmio_req = 1'b1; mmio_addr = BASE; mmio_wen = 1'b1; mmio_strb = 4'hF; mmio_wdata = 32'h55;
    step();
    g_resetn = 1'b0;
    #1;
    chk_reset("rst_mid");
    mmio_req = 1'b0; mmio_wen = 1'b0;
    model_reset();
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;

    // counting: 40 cycles, 10 inhibited, 12 retires of which 3 inhibited
    for (int i = 0; i < 40; i++) begin
      inhibit_cy = (i < 10);
      instr_ret  = (i < 36) && (i % 3 == 0);
      inhibit_ir = (i < 9) && (i % 3 == 0);
      step();
    end
    instr_ret = 1'b0; inhibit_cy = 1'b0; inhibit_ir = 1'b0;
    chk("cnt_cycle", ctr_cycle, 64'd30);
    chk("cnt_instret", ctr_instret, 64'd9);
    chk("cnt_time", ctr_time, 64'd10);

    bus(BASE + 32'h8, 1'b0, 4'h0, 32'h0, rd, er);
    chk("cmp_lo_rst", 64'(rd), 64'hFFFF_FFFF);
    bus(BASE + 32'hC, 1'b0, 4'h0, 32'h0, rd, er);
    chk("cmp_hi_rst", 64'(rd), 64'hFFFF_FFFF);

    // interrupt at mtimecmp = 0x20
    bus(BASE + 32'hC, 1'b1, 4'hF, 32'h0, rd, er);
    bus(BASE + 32'h8, 1'b1, 4'hF, 32'h20, rd, er);
    cnt = 0;
    while (ctr_time != 64'h20 && cnt < 200) begin step(); cnt++; end
    chk("irq_wait", ctr_time, 64'h20);
    chk("irq_at_eq", 64'(int_mtime), 64'h0);
    step();
    chk("irq_rise", 64'(int_mtime), 64'h1);
    bus(BASE + 32'hC, 1'b1, 4'hF, 32'h1, rd, er);
    chk("irq_clr", 64'(int_mtime), 64'h0);

    // wrap of mtime
    bus(BASE + 32'h4, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, er);
    bus(BASE + 32'h0, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, er);
    cnt = 0;
    while (ctr_time != 64'h0 && cnt < 20) begin step(); cnt++; end
    chk("wrap", ctr_time, 64'h0);
    step();
    chk("wrap_irq", 64'(int_mtime), 64'h0);

    // byte-strobed write to mtimecmp lo
    bus(BASE + 32'hC, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, er);
    bus(BASE + 32'h8, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, er);
    bus(BASE + 32'h8, 1'b1, 4'b0010, 32'h0000_AB00, rd, er);
    bus(BASE + 32'h8, 1'b0, 4'h0, 32'h0, rd, er);
    chk("byte_lo", 64'(rd), 64'hFFFF_ABFF);

    // zero-strobe write is a clean no-op
    bus(BASE, 1'b1, 4'h0, 32'h0, rd, er);
    chk("strb0_err", 64'(er), 64'h0);

    // error cases
    bus(BASE + 32'h10, 1'b0, 4'h0, 32'h0, rd, er);
    chk("oob_err", 64'(er), 64'h1);
    chk("oob_rdata", 64'(rd), 64'h0);
    bus(BASE + 32'h2, 1'b1, 4'hF, 32'h0, rd, er);
    chk("misalign_err", 64'(er), 64'h1);
    bus(BASE - 32'h4, 1'b0, 4'h0, 32'h0, rd, er);
    chk("below_err", 64'(er), 64'h1);

    // back-to-back: req held high for 6 edges gives 3 grants
    mmio_req = 1'b1; mmio_addr = BASE; mmio_wen = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mmio_gnt) cnt++;
    end
    mmio_req = 1'b0;
    chk("b2b_gnts", 64'(cnt), 64'd3);

    // randomized traffic and control
    addrs[0] = BASE;          addrs[1] = BASE + 32'h4; addrs[2] = BASE + 32'h8;
    addrs[3] = BASE + 32'hC;  addrs[4] = BASE + 32'h2; addrs[5] = BASE + 32'h10;
    rnd_on = 1'b1;
    for (int k = 0; k < 80; k++) begin
      repeat ($urandom_range(0, 2)) step();
      bus(addrs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), $urandom, rd, er);
    end
    rnd_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
